// File: rtl/div_seq.sv
// Multi-cycle 32-bit divide sequencer for RISC-V DIV/DIVU/REM/REMU.
// Radix-2 restoring division, one quotient bit per cycle, with a fast path for b==0 and signed overflow.
module div_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        flush,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q;
   logic [31:0] rem_q, quo_q, div_q;
   logic        negq_q, negr_q, sel_rem_q;

   logic        accept, is_signed, div_zero, ovf, fast;
   logic [31:0] abs_a, abs_b;
   logic [32:0] shifted, trial;
   logic [31:0] rem_n, quo_n, fin_quo, fin_rem;

   assign accept    = (state_q == IDLE) & start & ~flush;
   assign is_signed = ~op[0];
   assign div_zero  = (b == 32'd0);
   assign ovf       = is_signed & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
   assign fast      = div_zero | ovf;
   assign abs_a     = (is_signed & a[31]) ? (~a + 32'd1) : a;
   assign abs_b     = (is_signed & b[31]) ? (~b + 32'd1) : b;

   // One restoring step: shift {rem,quo} left, keep the trial difference if it did not borrow.
   assign shifted = {rem_q, quo_q[31]};
   assign trial   = shifted - {1'b0, div_q};
   assign rem_n   = trial[32] ? shifted[31:0] : trial[31:0];
   assign quo_n   = {quo_q[30:0], ~trial[32]};
   assign fin_quo = negq_q ? (~quo_n + 32'd1) : quo_n;
   assign fin_rem = negr_q ? (~rem_n + 32'd1) : rem_n;

   assign stall = accept | (state_q == BUSY);
   assign busy  = (state_q == BUSY);
   assign done  = (state_q == DONE);

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = fast ? DONE : BUSY;
         BUSY: if (cnt_q == 5'd31) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         div_q     <= '0;
         negq_q    <= 1'b0;
         negr_q    <= 1'b0;
         sel_rem_q <= 1'b0;
         result    <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               sel_rem_q <= op[1];
               cnt_q     <= '0;
               if (div_zero)
                  result <= op[1] ? a : 32'hFFFF_FFFF;
               else if (ovf)
                  result <= op[1] ? 32'd0 : 32'h8000_0000;
               else begin
                  // Working registers hold magnitudes; signs are reapplied at the end.
                  rem_q  <= '0;
                  quo_q  <= abs_a;
                  div_q  <= abs_b;
                  negq_q <= is_signed & (a[31] ^ b[31]);
                  negr_q <= is_signed & a[31];
               end
            end
            BUSY: begin
               rem_q <= rem_n;
               quo_q <= quo_n;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31)
                  result <= sel_rem_q ? fin_rem : fin_quo;
            end
            default: ;
         endcase
      end
   end

endmodule
